// File: rtl/cardinal_nic_host.sv
// Processor-side master for one cardinal_nic: it writes local tx packets into the NIC
// output buffer and reads NIC input packets out to a local sink.
// One packet is held per direction. TX waits for the out-status poll to show empty.
// RX polling stops while a received packet waits on rx_ready.
module cardinal_nic_host #(
  parameter int STATUS_BIT = 63,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tx_valid,
  input  logic [63:0]      tx_data,
  output logic             tx_ready,
  output logic             rx_valid,
  output logic [63:0]      rx_data,
  input  logic             rx_ready,
  output logic [1:0]       addr_nic,
  output logic [63:0]      d_in,
  output logic             nicEn,
  output logic             nicWrEn,
  input  logic [63:0]      d_out,
  output logic [CNT_W-1:0] tx_count,
  output logic [CNT_W-1:0] rx_count
);

  typedef enum logic [2:0] {
    IDLE, TX_STAT, TX_CHK, TX_WRITE, RX_STAT, RX_CHK, RX_READ, RX_CAPT
  } state_t;

  localparam logic [1:0] ADDR_IN_BUF   = 2'b00;
  localparam logic [1:0] ADDR_IN_STAT  = 2'b01;
  localparam logic [1:0] ADDR_OUT_BUF  = 2'b10;
  localparam logic [1:0] ADDR_OUT_STAT = 2'b11;

  state_t      state, state_nxt;
  logic        tx_full;
  logic [63:0] tx_hold;
  logic        last_rx;   // 1 when RX was the most recently granted side
  logic        tx_req, rx_req;
  logic        grant_tx, grant_rx;
  logic        load_din;

  assign tx_ready = ~tx_full;

  // Next-state, arbitration and NIC bus decode
  always_comb begin
    state_nxt = state;
    nicEn     = 1'b0;
    nicWrEn   = 1'b0;
    addr_nic  = ADDR_IN_BUF;
    grant_tx  = 1'b0;
    grant_rx  = 1'b0;
    load_din  = 1'b0;
    tx_req    = tx_full;
    rx_req    = ~rx_valid;
    case (state)
      IDLE: begin
        // With both sides pending, serve the side that did not go last
        if (tx_req && (!rx_req || last_rx)) begin
          grant_tx  = 1'b1;
          state_nxt = TX_STAT;
        end else if (rx_req) begin
          grant_rx  = 1'b1;
          state_nxt = RX_STAT;
        end
      end
      TX_STAT: begin
        nicEn     = 1'b1;
        addr_nic  = ADDR_OUT_STAT;
        state_nxt = TX_CHK;
      end
      TX_CHK: begin
        addr_nic = ADDR_OUT_STAT;
        // A full output buffer sends us back to arbitration rather than spinning here
        if (d_out[STATUS_BIT]) begin
          state_nxt = IDLE;
        end else begin
          load_din  = 1'b1;
          state_nxt = TX_WRITE;
        end
      end
      TX_WRITE: begin
        nicEn     = 1'b1;
        nicWrEn   = 1'b1;
        addr_nic  = ADDR_OUT_BUF;
        state_nxt = IDLE;
      end
      RX_STAT: begin
        nicEn     = 1'b1;
        addr_nic  = ADDR_IN_STAT;
        state_nxt = RX_CHK;
      end
      RX_CHK: begin
        addr_nic  = ADDR_IN_STAT;
        state_nxt = d_out[STATUS_BIT] ? RX_READ : IDLE;
      end
      RX_READ: begin
        nicEn     = 1'b1;
        addr_nic  = ADDR_IN_BUF;
        state_nxt = RX_CAPT;
      end
      RX_CAPT: begin
        addr_nic  = ADDR_IN_BUF;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register and arbitration history
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      last_rx <= 1'b1;
    end else begin
      state <= state_nxt;
      if (grant_tx) last_rx <= 1'b0;
      else if (grant_rx) last_rx <= 1'b1;
    end
  end

  // TX holding register; the slot frees in the write cycle itself
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_full <= 1'b0;
      tx_hold <= '0;
    end else if (state == TX_WRITE) begin
      tx_full <= 1'b0;
    end else if (tx_valid && tx_ready) begin
      tx_hold <= tx_data;
      tx_full <= 1'b1;
    end
  end

  // Write data bus: loaded just before the write cycle, held otherwise
  always_ff @(posedge clk) begin
    if (reset) d_in <= '0;
    else if (load_din) d_in <= tx_hold;
  end

  // RX holding register: captured from the NIC, released on the sink handshake
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_valid <= 1'b0;
      rx_data  <= '0;
    end else if (state == RX_CAPT) begin
      rx_valid <= 1'b1;
      rx_data  <= d_out;
    end else if (rx_valid && rx_ready) begin
      rx_valid <= 1'b0;
    end
  end

  // Packet counters, wrapping freely
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_count <= '0;
      rx_count <= '0;
    end else begin
      if (state == TX_WRITE) tx_count <= tx_count + 1'b1;
      if (state == RX_CAPT)  rx_count <= rx_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_cardinal_nic_host.sv
module tb_cardinal_nic_host;

  logic        clk = 1'b0;
  logic        reset;
  logic        tx_valid;
  logic [63:0] tx_data;
  logic        tx_ready;
  logic        rx_valid;
  logic [63:0] rx_data;
  logic        rx_ready;
  logic [1:0]  addr_nic;
  logic [63:0] d_in;
  logic        nicEn;
  logic        nicWrEn;
  logic [63:0] d_out;
  logic [15:0] tx_count;
  logic [15:0] rx_count;

  always #5 clk = ~clk;

  cardinal_nic_host #(.STATUS_BIT(63), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .addr_nic(addr_nic), .d_in(d_in), .nicEn(nicEn), .nicWrEn(nicWrEn),
    .d_out(d_out), .tx_count(tx_count), .rx_count(rx_count)
  );

  int checks = 0;
  int errors = 0;

  // NIC model state and scoreboards
  int          out_full_polls;
  logic        in_full;
  logic [63:0] in_buf;
  bit          in_refill;
  int          out_stat_reads, in_side_reads, bad_writes;
  bit          saw_tx_stat;
  logic [63:0] src_q[$];
  logic [63:0] exp_tx_q[$];
  logic [63:0] exp_rx_q[$];
  logic [63:0] wr_log[$];
  logic [63:0] rx_log[$];
  int          grant_log[$];   // 1 = TX status poll, 0 = RX status poll

  task automatic load_in(input logic [63:0] v);
    in_buf  = v;
    in_full = 1'b1;
    exp_rx_q.push_back(v);
  endtask

  // One clock: drive source, sample bus mid-cycle, apply NIC response after the edge
  task automatic tick();
    logic        s_en, s_we, s_txhs, s_rxhs;
    logic [1:0]  s_addr;
    logic [63:0] s_din, s_rxd;
    tx_valid = (src_q.size() != 0);
    tx_data  = (src_q.size() != 0) ? src_q[0] : 64'd0;
    #1;
    s_txhs = tx_valid && tx_ready;
    s_rxhs = rx_valid && rx_ready;
    s_rxd  = rx_data;
    s_en   = nicEn;
    s_we   = nicWrEn;
    s_addr = addr_nic;
    s_din  = d_in;
    saw_tx_stat = 1'b0;
    @(posedge clk);
    #1;
    if (s_txhs) exp_tx_q.push_back(src_q.pop_front());
    if (s_rxhs) rx_log.push_back(s_rxd);
    if (s_en && s_we) begin
      if (s_addr == 2'b10) wr_log.push_back(s_din);
      else bad_writes++;
    end
    if (s_en && !s_we) begin
      case (s_addr)
        2'b11: begin
          out_stat_reads++;
          grant_log.push_back(1);
          saw_tx_stat = 1'b1;
          d_out = {(out_full_polls > 0), 63'h5A5A_0F0F};
          if (out_full_polls > 0) out_full_polls--;
        end
        2'b01: begin
          in_side_reads++;
          grant_log.push_back(0);
          d_out = {in_full, 63'h3C3C};
        end
        2'b00: begin
          in_side_reads++;
          d_out   = in_buf;
          in_full = 1'b0;
          if (in_refill) load_in(in_buf + 64'h0000_0001_0000_0011);
        end
        default: d_out = 64'd0;
      endcase
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    rx_ready = 1'b0;
    repeat (3) tick();
    checks++;
    if ({tx_ready, rx_valid, nicEn, nicWrEn, addr_nic} !== 6'b100000) begin
      errors++;
      $display("FAIL reset_ctl: got %b expected 100000", {tx_ready, rx_valid, nicEn, nicWrEn, addr_nic});
    end
    checks++;
    if ({d_in, rx_data, tx_count, rx_count} !== 160'd0) begin
      errors++;
      $display("FAIL reset_data: d_in=%h rx_data=%h tx_count=%0d rx_count=%0d expected all 0", d_in, rx_data, tx_count, rx_count);
    end
    reset = 1'b0;
  endtask

  task automatic test_idle_poll();
    for (int i = 0; i < 12; i++) begin
      checks++;
      if (nicEn !== (i % 3 == 1) || (nicEn && (addr_nic !== 2'b01 || nicWrEn !== 1'b0))) begin
        errors++;
        $display("FAIL idle_poll[%0d]: got en=%b we=%b addr=%b expected en=%b addr=01", i, nicEn, nicWrEn, addr_nic, (i % 3 == 1));
      end
      tick();
    end
    checks++;
    if ({tx_ready, rx_valid, tx_count, rx_count} !== {2'b10, 32'd0}) begin
      errors++;
      $display("FAIL idle_state: got ready=%b valid=%b tx=%0d rx=%0d expected 1 0 0 0", tx_ready, rx_valid, tx_count, rx_count);
    end
  endtask

  task automatic test_single_tx();
    int n;
    wr_log.delete();
    src_q.push_back(64'hDEAD_BEEF_0000_0001);
    n = 0;
    while (wr_log.size() == 0 && n < 40) begin tick(); n++; end
    repeat (12) tick();
    checks++;
    if (wr_log.size() != 1 || exp_tx_q.size() != 1 || bad_writes != 0) begin
      errors++;
      $display("FAIL single_tx_count: got writes=%0d bad=%0d expected 1 0", wr_log.size(), bad_writes);
    end else begin
      checks++;
      if (wr_log[0] !== exp_tx_q[0]) begin
        errors++;
        $display("FAIL single_tx_data: got %h expected %h", wr_log[0], exp_tx_q[0]);
      end
    end
    exp_tx_q.delete();
    checks++;
    if (tx_count !== 16'd1 || tx_ready !== 1'b1) begin
      errors++;
      $display("FAIL single_tx_state: got tx_count=%0d ready=%b expected 1 1", tx_count, tx_ready);
    end
  endtask

  task automatic test_out_full();
    int n, reads_at_write;
    wr_log.delete();
    out_stat_reads = 0;
    out_full_polls = 4;
    src_q.push_back(64'hBEEF_0000_CAFE_0002);
    n = 0;
    while (wr_log.size() == 0 && n < 100) begin tick(); n++; end
    reads_at_write = out_stat_reads;
    repeat (15) tick();
    checks++;
    if (reads_at_write != 5) begin
      errors++;
      $display("FAIL out_full_polls: got write after %0d polls expected 5", reads_at_write);
    end
    checks++;
    if (wr_log.size() != 1 || exp_tx_q.size() != 1) begin
      errors++;
      $display("FAIL out_full_writes: got %0d expected 1", wr_log.size());
    end else begin
      checks++;
      if (wr_log[0] !== exp_tx_q[0]) begin
        errors++;
        $display("FAIL out_full_data: got %h expected %h", wr_log[0], exp_tx_q[0]);
      end
    end
    exp_tx_q.delete();
    checks++;
    if (tx_count !== 16'd2) begin
      errors++;
      $display("FAIL out_full_count: got %0d expected 2", tx_count);
    end
  endtask

  task automatic test_rx_hold();
    int n;
    logic [63:0] first;
    rx_ready = 1'b0;
    rx_log.delete();
    load_in(64'h0123_4567_89AB_CDEF);
    n = 0;
    while (rx_valid !== 1'b1 && n < 30) begin tick(); n++; end
    checks++;
    if (rx_valid !== 1'b1 || rx_data !== exp_rx_q[0]) begin
      errors++;
      $display("FAIL rx_arrive: got valid=%b data=%h expected 1 %h", rx_valid, rx_data, exp_rx_q[0]);
    end
    first = rx_data;
    in_side_reads = 0;
    repeat (10) tick();
    checks++;
    if (rx_valid !== 1'b1 || rx_data !== first || in_side_reads != 0) begin
      errors++;
      $display("FAIL rx_hold: got valid=%b data=%h reads=%0d expected 1 %h 0", rx_valid, rx_data, in_side_reads, first);
    end
    rx_ready = 1'b1;
    tick();
    checks++;
    if (rx_valid !== 1'b0 || rx_log.size() != 1) begin
      errors++;
      $display("FAIL rx_release: got valid=%b handshakes=%0d expected 0 1", rx_valid, rx_log.size());
    end else begin
      checks++;
      if (rx_log[0] !== exp_rx_q[0]) begin
        errors++;
        $display("FAIL rx_data: got %h expected %h", rx_log[0], exp_rx_q[0]);
      end
    end
    exp_rx_q.delete();
    rx_log.delete();
    in_side_reads = 0;
    repeat (6) tick();
    checks++;
    if (in_side_reads == 0 || rx_count !== 16'd1) begin
      errors++;
      $display("FAIL rx_resume: got reads=%0d rx_count=%0d expected >0 1", in_side_reads, rx_count);
    end
  endtask

  task automatic test_back_to_back();
    int n, k;
    bit alt_ok;
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    wr_log.delete(); rx_log.delete(); exp_tx_q.delete(); exp_rx_q.delete(); grant_log.delete();
    rx_ready  = 1'b1;
    in_refill = 1'b1;
    load_in(64'hA000_0000_0000_0000);
    for (int i = 0; i < 4; i++) src_q.push_back(64'h7000_0000_0000_0000 + 64'(i));
    n = 0;
    while (wr_log.size() < 4 && n < 150) begin tick(); n++; end
    in_refill = 1'b0;
    repeat (25) tick();
    k = 0;
    while (k < grant_log.size() && grant_log[k] != 1) k++;
    alt_ok = (k <= 1) && (grant_log.size() >= k + 7);
    for (int i = 0; i < 7; i++)
      if (alt_ok && grant_log[k + i] != ((i % 2 == 0) ? 1 : 0)) alt_ok = 1'b0;
    checks++;
    if (!alt_ok) begin
      errors++;
      $display("FAIL alternate: got first TX at %0d of %0d grants, pattern broken; expected T,R,T,R...", k, grant_log.size());
    end
    checks++;
    if (wr_log.size() != 4 || exp_tx_q.size() != 4 || tx_count !== 16'd4) begin
      errors++;
      $display("FAIL b2b_tx_count: got writes=%0d tx_count=%0d expected 4 4", wr_log.size(), tx_count);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (wr_log[i] !== exp_tx_q[i]) begin
          errors++;
          $display("FAIL b2b_tx_data[%0d]: got %h expected %h", i, wr_log[i], exp_tx_q[i]);
        end
      end
    end
    checks++;
    if (rx_log.size() < 4 || rx_log.size() != exp_rx_q.size() || rx_count !== 16'(rx_log.size())) begin
      errors++;
      $display("FAIL b2b_rx_count: got handshakes=%0d expected=%0d rx_count=%0d", rx_log.size(), exp_rx_q.size(), rx_count);
    end else begin
      for (int i = 0; i < rx_log.size(); i++) begin
        checks++;
        if (rx_log[i] !== exp_rx_q[i]) begin
          errors++;
          $display("FAIL b2b_rx_data[%0d]: got %h expected %h", i, rx_log[i], exp_rx_q[i]);
        end
      end
    end
    wr_log.delete(); rx_log.delete(); exp_tx_q.delete(); exp_rx_q.delete();
  endtask

  task automatic test_reset_mid();
    int n;
    src_q.push_back(64'h5555_AAAA_1234_5678);
    n = 0;
    tick();
    while (!saw_tx_stat && n < 40) begin tick(); n++; end
    checks++;
    if (!saw_tx_stat) begin
      errors++;
      $display("FAIL reset_mid_reach: got no TX status poll expected one within 40 cycles");
    end
    reset = 1'b1;
    tick();
    checks++;
    if ({tx_ready, rx_valid, nicEn, nicWrEn, addr_nic} !== 6'b100000 ||
        {d_in, rx_data, tx_count, rx_count} !== 160'd0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got ready=%b valid=%b en=%b we=%b addr=%b d_in=%h tx=%0d rx=%0d expected reset values",
               tx_ready, rx_valid, nicEn, nicWrEn, addr_nic, d_in, tx_count, rx_count);
    end
    reset = 1'b0;
    exp_tx_q.delete();
    repeat (15) tick();
    checks++;
    if (wr_log.size() != 0 || tx_count !== 16'd0 || tx_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_drop: got writes=%0d tx_count=%0d ready=%b expected 0 0 1", wr_log.size(), tx_count, tx_ready);
    end
  endtask

  initial begin
    reset = 1'b1; tx_valid = 1'b0; tx_data = 64'd0; rx_ready = 1'b0; d_out = 64'd0;
    out_full_polls = 0; in_full = 1'b0; in_buf = 64'd0; in_refill = 1'b0;
    out_stat_reads = 0; in_side_reads = 0; bad_writes = 0; saw_tx_stat = 1'b0;
    @(negedge clk);
    test_reset();
    test_idle_poll();
    test_single_tx();
    test_out_full();
    test_rx_hold();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cardinal_nic_host.md
Name: cardinal_nic_host

Overview:
- Processor-side master for one cardinal_nic; drives its 2-bit register interface (addr/d_in/nicEn/nicWrEn, data returned on d_out).
- Accepts 64-bit packets from a local source over valid/ready and writes them into the NIC output channel buffer once the output status shows empty.
- Polls the NIC input channel status, reads arriving packets, and presents them to a local sink over valid/ready.
- One instance sits beside each NIC in nic_router-based test systems, replacing hand-written processor stimulus.

Parameters:
- STATUS_BIT, 63, bit of the 64-bit status word that carries the channel-full flag.
- CNT_W, 16, width of the tx/rx packet counters.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- tx_valid  in  1  local source has a packet
- tx_data  in  64  packet to send (cardinal packet format, passed through untouched)
- tx_ready  out  1  host can accept tx_data this cycle
- rx_valid  out  1  received packet available on rx_data
- rx_data  out  64  received packet
- rx_ready  in  1  local sink accepts rx_data
- addr_nic  out  2  NIC register address: 00 in-buf, 01 in-status, 10 out-buf, 11 out-status
- d_in  out  64  write data to NIC
- nicEn  out  1  NIC access enable
- nicWrEn  out  1  1 = write, 0 = read
- d_out  in  64  NIC read data
- tx_count  out  CNT_W  packets written to NIC
- rx_count  out  CNT_W  packets read from NIC

Behaviour:
- Clocking and reset: single clock; all state updates on the rising edge of clk. Reset is synchronous, active-high, and overrides everything.
- Reset values: state=IDLE, tx_ready=1, rx_valid=0, rx_data=0, addr_nic=00, d_in=0, nicEn=0, nicWrEn=0, counts=0, last_srv=RX (TX gets first priority).
- Tx holding register:
  - tx_ready = ~tx_full.
  - On tx_valid & tx_ready, latch tx_data and set tx_full.
  - tx_full clears in the TX_WRITE cycle.
  - Accepting a new packet in that same cycle is not allowed: tx_ready is 0 there.
- Rx holding register:
  - rx_valid is set when RX_CAPT latches d_out.
  - rx_valid clears on rx_valid & rx_ready.
  - While rx_valid=1, no RX polling is started.
- NIC read timing: the read is issued in cycle N (nicEn=1, nicWrEn=0, addr_nic driven). d_out is valid and sampled in cycle N+1. nicEn=0 in N+1.
- FSM states: IDLE, TX_STAT, TX_CHK, TX_WRITE, RX_STAT, RX_CHK, RX_READ, RX_CAPT.
- IDLE: arbitrate between tx_req=tx_full and rx_req=~rx_valid.
  - Both requesting: serve the side opposite last_srv.
  - One requesting: serve it.
  - Update last_srv on each grant.
- TX_STAT: read addr 11 -> TX_CHK.
- TX_CHK: if d_out[STATUS_BIT]=1 (output buffer full) -> IDLE (re-arbitrate, no busy lock); else -> TX_WRITE.
- TX_WRITE: nicEn=1, nicWrEn=1, addr_nic=10, d_in=held packet, tx_count+1 -> IDLE.
- RX_STAT: read addr 01 -> RX_CHK.
- RX_CHK: if d_out[STATUS_BIT]=0 -> IDLE; else -> RX_READ.
- RX_READ: read addr 00 -> RX_CAPT.
- RX_CAPT: rx_data<=d_out, rx_valid<=1, rx_count+1 -> IDLE. The NIC clears its input-full flag on the read.
- Bus idle values: nicEn=0 and nicWrEn=0 outside the issuing states; d_in holds its last value.
- Counters wrap modulo 2^CNT_W without saturation.
- Starvation bound: with both sides pending continuously, TX and RX alternate. Worst-case gap between TX attempts is one RX sequence (5 cycles incl. IDLE).
- Reset mid-operation: any in-flight access is abandoned. A write is never partially committed because it is a single cycle. A held tx packet is dropped.

Test Plan:
- Reset then idle, NIC status always 0 -> nicEn toggles only for 01 status polls every 3 cycles; tx_ready=1, rx_valid=0, counts=0.
- tx_data=64'hDEAD_BEEF_0000_0001 with out-status 0 -> exactly one write: addr 10, d_in=that value, nicWrEn=1; tx_count=1; tx_ready returns to 1.
- Out-status bit63=1 for 4 polls then 0 -> no write while full, write on the first empty poll, then a single write only.
- In-status bit63=1, in-buf=64'h0123_4567_89AB_CDEF, rx_ready=0 -> rx_valid=1 with that data, held stable, no further 01/00 reads. Raise rx_ready -> rx_valid drops, polling resumes.
- TX pending and RX available simultaneously -> grants alternate TX, RX, TX… (first TX after reset); both counts advance.
- Reset asserted during TX_WRITE preparation (TX_CHK) -> next cycle all outputs at reset values, no write issued, tx_count=0.
